// File: rtl/led_pattern_pkg.sv
// Purpose: shared constants for the LED pattern engine and its prescaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: pattern mode codes, bounce direction encoding and the PWM
// period used by the optional dimming stage (LED_PATTERN_PWM_DIM_EN).

package led_pattern_pkg;

    // Pattern codes carried on the 3-bit mode input. Codes 6 and 7 are
    // reserved and decode exactly like MODE_OFF.
    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_CHASE  = 3'd1;
    localparam logic [2:0] MODE_BOUNCE = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;
    localparam logic [2:0] MODE_COUNT  = 3'd4;
    localparam logic [2:0] MODE_FILL   = 3'd5;

    // Bounce travel direction.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // PWM counter runs 0..PWM_STEPS-1, so brightness 15 means always on.
    localparam int PWM_STEPS = 15;

endpackage : led_pattern_pkg

// File: rtl/led_step_prescaler.sv
// Purpose: divides clk down to a one-cycle step tick every max(1, STEP_CYCLES >> speed) cycles.
// Latency: tick is combinational from the counter; it is high in the cycle the counter wraps.
// Backpressure: none; pause freezes the counter, restart clears it and suppresses the tick.
//
// Ports:
//   clk, rst_n  fabric clock, synchronous active-low reset
//   speed[1:0]  period shift: period = max(1, STEP_CYCLES >> speed)
//   pause       level, holds the counter and blocks the tick
//   restart     single-cycle clear (wins over pause and tick)
//   tick        one-cycle pulse on each step

module led_step_prescaler #(
    parameter int unsigned STEP_CYCLES = 16_666_667
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       restart,
    output logic       tick
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      period;
    logic [31:0]      last_cnt;

    // Period is recomputed every cycle so speed can change at any time.
    always_comb begin
        period = 32'(STEP_CYCLES) >> speed;
        if (period == 32'd0) begin
            period = 32'd1;
        end
        last_cnt = period - 32'd1;
    end

    // ">=" rather than "==": if speed is raised mid-count and the counter is
    // already past the new terminal value, step on the next cycle instead of
    // running all the way round the counter.
    assign tick = !restart && !pause && (32'(cnt_q) >= last_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || tick) begin
            cnt_q <= '0;
        end else if (!pause) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule : led_step_prescaler

// File: rtl/led_pattern_engine.sv
// Purpose: drives NUM_LEDS board LEDs with one of six runtime-selectable step patterns.
// Latency: mode_load -> initial pattern on leds after 1 clk; step_tick and the new pattern appear together.
// Backpressure: none; pause freezes pattern and prescaler, mode_load overrides pause and a coincident step.
//
// Ports:
//   clk, rst_n        fabric clock, synchronous active-low reset
//   mode[2:0]         pattern code, sampled only while mode_load=1
//   mode_load         single-cycle pulse: latch mode, restart pattern and prescaler
//   pause             level, freezes the pattern and the prescaler
//   speed[1:0]        step period = max(1, STEP_CYCLES >> speed)
//   brightness[3:0]   only with LED_PATTERN_PWM_DIM_EN: 0 dark .. 15 always on
//   leds[NUM_LEDS]    registered pattern output
//   step_tick         registered one-cycle pulse on each pattern advance
//
// Optional feature macro: LED_PATTERN_PWM_DIM_EN (PWM dimming of the leds output).

module led_pattern_engine #(
    parameter int          NUM_LEDS    = 4,
    parameter int unsigned STEP_CYCLES = 16_666_667
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          mode,
    input  logic                mode_load,
    input  logic                pause,
    input  logic [1:0]          speed,
`ifdef LED_PATTERN_PWM_DIM_EN
    input  logic [3:0]          brightness,
`endif
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_tick
);

    import led_pattern_pkg::*;

    localparam logic [NUM_LEDS-1:0] PAT_ONE = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] PAT_ALL = '1;

    logic [2:0]          mode_q, mode_d;
    logic                dir_q, dir_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic [NUM_LEDS-1:0] pat_shl, pat_shr;
    logic                tick;

    // mode_load doubles as the prescaler restart so the first step of a new
    // pattern always comes one full period after the load.
    led_step_prescaler #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .speed   (speed),
        .pause   (pause),
        .restart (mode_load),
        .tick    (tick)
    );

    // Next-state for mode, bounce direction and pattern register.
    // The prescaler never ticks while paused or during a load, so pause needs
    // no explicit term here.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;
        pat_shl = pat_q << 1;
        pat_shr = pat_q >> 1;

        if (mode_load) begin
            mode_d = mode;
            dir_d  = DIR_UP;
            case (mode)
                MODE_CHASE,
                MODE_BOUNCE,
                MODE_FILL:   pat_d = PAT_ONE;
                MODE_BLINK:  pat_d = PAT_ALL;
                MODE_OFF,
                MODE_COUNT:  pat_d = '0;
                default:     pat_d = '0;
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_CHASE: begin
                    pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
                end
                MODE_BOUNCE: begin
                    // Direction flips on reaching an end so each endpoint is
                    // shown for exactly one step.
                    if (dir_q == DIR_UP) begin
                        pat_d = pat_shl;
                        if (pat_shl[NUM_LEDS-1]) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        pat_d = pat_shr;
                        if (pat_shr[0]) begin
                            dir_d = DIR_UP;
                        end
                    end
                end
                MODE_BLINK: begin
                    pat_d = ~pat_q;
                end
                MODE_COUNT: begin
                    pat_d = pat_q + PAT_ONE;
                end
                MODE_FILL: begin
                    // Thermometer fill, then one all-dark step before restarting.
                    if (&pat_q) begin
                        pat_d = '0;
                    end else begin
                        pat_d = pat_shl | PAT_ONE;
                    end
                end
                default: begin
                    pat_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_OFF;
            dir_q     <= DIR_UP;
            pat_q     <= '0;
            step_tick <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            pat_q     <= pat_d;
            step_tick <= tick;
        end
    end

`ifdef LED_PATTERN_PWM_DIM_EN
    // Free-running PWM, 15 slots per period. The mask is applied to the
    // next pattern value so leds stays registered without adding a cycle of
    // latency relative to step_tick.
    logic [3:0]          pwm_cnt;
    logic [NUM_LEDS-1:0] leds_q;
    logic                pwm_on;

    assign pwm_on = (pwm_cnt < brightness);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= 4'd0;
            leds_q  <= '0;
        end else begin
            if (pwm_cnt == 4'(PWM_STEPS - 1)) begin
                pwm_cnt <= 4'd0;
            end else begin
                pwm_cnt <= pwm_cnt + 4'd1;
            end
            leds_q <= pat_d & {NUM_LEDS{pwm_on}};
        end
    end

    assign leds = leds_q;
`else
    assign leds = pat_q;
`endif

endmodule : led_pattern_engine
